// File: rtl/cpu_sequencer_pkg.sv
// Shared sequencer symbols: opcodes, FSM states, address-select and jump-condition codes.
// Imported by the sequencer, its wait timer and the testbench.
package cpu_sequencer_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDI  = 8'h10;
  localparam logic [7:0] OP_MOV  = 8'h11;
  localparam logic [7:0] OP_ALU  = 8'h20;
  localparam logic [7:0] OP_CMP  = 8'h21;
  localparam logic [7:0] OP_LDX  = 8'h30;
  localparam logic [7:0] OP_STX  = 8'h31;
  localparam logic [7:0] OP_PUSH = 8'h40;
  localparam logic [7:0] OP_POP  = 8'h41;
  localparam logic [7:0] OP_JMP  = 8'h50;
  localparam logic [7:0] OP_CALL = 8'h51;
  localparam logic [7:0] OP_RET  = 8'h52;
  localparam logic [7:0] OP_HLT  = 8'hFF;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_IMM    = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ADDR_PC  = 2'b00,
    ADDR_OPR = 2'b01,
    ADDR_SP  = 2'b10
  } addr_sel_t;

  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_Z      = 3'b001;
  localparam logic [2:0] COND_NZ     = 3'b010;
  localparam logic [2:0] COND_C      = 3'b011;
  localparam logic [2:0] COND_NC     = 3'b100;

  // Codes 101-111 are reserved and never take the jump.
  function automatic logic cond_met(input logic [2:0] cond, input logic z, input logic c);
    case (cond)
      COND_ALWAYS: cond_met = 1'b1;
      COND_Z:      cond_met = z;
      COND_NZ:     cond_met = !z;
      COND_C:      cond_met = c;
      COND_NC:     cond_met = !c;
      default:     cond_met = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_sequencer_mem_wait_timer.sv
// Counts consecutive un-acknowledged memory request cycles; clears on ack or idle.
// timeout is high when the current request cycle is the last one allowed.
module mem_wait_timer
  import cpu_sequencer_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ack,
  output logic timeout
);

  localparam int unsigned   CW   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!req || ack) begin
      cnt_q <= '0;
    end else if (cnt_q != LAST) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Registered compare only; the caller qualifies with the live req/ack so
  // no combinational path runs back through the request strobe.
  assign timeout = (cnt_q == LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: fetch/decode/immediate/execute/memory control FSM
// driving datapath strobes, with a bounded wait on every memory request.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] opcode,
  input  logic [2:0] cond,
  input  logic       flag_z,
  input  logic       flag_c,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic [1:0] addr_sel,
  output logic       ir_load,
  output logic       tmp_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       sp_inc,
  output logic       sp_dec,
  output logic       reg_we,
  output logic       flags_we,
  output logic       halted,
  output logic       bus_err,
  output logic [2:0] state
);

  state_t     state_q, state_d;
  logic [7:0] op_q, op_d;
  logic       sp_done_q, sp_done_d;
  logic       bus_err_q, bus_err_d;
  logic       timeout;
  addr_sel_t  addr_sel_e;

  mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (mem_req),
    .ack    (mem_ack),
    .timeout(timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      op_q      <= OP_NOP;
      sp_done_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sp_done_q <= sp_done_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sp_done_d  = 1'b0;
    bus_err_d  = bus_err_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel_e = ADDR_PC;
    ir_load    = 1'b0;
    tmp_load   = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    sp_inc     = 1'b0;
    sp_dec     = 1'b0;
    reg_we     = 1'b0;
    flags_we   = 1'b0;
    halted     = 1'b0;

    // Outputs are gated by rst_n so they drop the instant reset asserts.
    if (rst_n) begin
      case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_load = 1'b1;
            pc_inc  = 1'b1;
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: begin
          op_d = opcode;
          case (opcode)
            OP_LDI, OP_JMP, OP_CALL:                 state_d = ST_IMM;
            OP_HLT:                                  state_d = ST_HALT;
            OP_NOP:                                  state_d = ST_FETCH;
            OP_LDX, OP_STX, OP_PUSH, OP_POP, OP_RET: state_d = ST_MEM;
            default:                                 state_d = ST_EXEC;
          endcase
        end
        ST_IMM: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            tmp_load = 1'b1;
            pc_inc   = 1'b1;
            state_d  = (op_q == OP_CALL) ? ST_MEM : ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (op_q)
            OP_ALU: begin
              reg_we   = 1'b1;
              flags_we = 1'b1;
            end
            OP_CMP:         flags_we = 1'b1;
            OP_MOV, OP_LDI: reg_we   = 1'b1;
            OP_JMP:         pc_load  = cond_met(cond, flag_z, flag_c);
            default:        ;
          endcase
          state_d = ST_FETCH;
        end
        ST_MEM: begin
          case (op_q)
            OP_LDX: begin
              mem_req    = 1'b1;
              addr_sel_e = ADDR_OPR;
              if (mem_ack) begin
                reg_we  = 1'b1;
                state_d = ST_FETCH;
              end
            end
            OP_STX: begin
              mem_req    = 1'b1;
              mem_we     = 1'b1;
              addr_sel_e = ADDR_OPR;
              if (mem_ack) state_d = ST_FETCH;
            end
            // Stack pushes take one SP-adjust cycle before the write request.
            OP_PUSH, OP_CALL: begin
              sp_done_d = 1'b1;
              if (!sp_done_q) begin
                sp_dec = 1'b1;
              end else begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                addr_sel_e = ADDR_SP;
                if (mem_ack) begin
                  pc_load   = (op_q == OP_CALL);
                  sp_done_d = 1'b0;
                  state_d   = ST_FETCH;
                end
              end
            end
            OP_POP, OP_RET: begin
              mem_req    = 1'b1;
              addr_sel_e = ADDR_SP;
              if (mem_ack) begin
                sp_inc  = 1'b1;
                reg_we  = (op_q == OP_POP);
                pc_load = (op_q == OP_RET);
                state_d = ST_FETCH;
              end
            end
            default: state_d = ST_FETCH;
          endcase
        end
        ST_HALT: halted = 1'b1;
        default: state_d = ST_FETCH;
      endcase

      if (mem_req && !mem_ack && timeout) begin
        state_d   = ST_HALT;
        sp_done_d = 1'b0;
        bus_err_d = 1'b1;
      end
    end
  end

  assign addr_sel = addr_sel_e;
  assign bus_err  = bus_err_q;
  assign state    = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Table-driven bench for cpu_sequencer: per-cycle expected output words are
// queued as stimulus is driven and compared on the falling clock edge.
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  logic       clk, rst_n;
  logic [7:0] opcode;
  logic [2:0] cond;
  logic       flag_z, flag_c, mem_ack;
  logic       mem_req, mem_we, ir_load, tmp_load, pc_inc, pc_load;
  logic       sp_inc, sp_dec, reg_we, flags_we, halted, bus_err;
  logic [1:0] addr_sel;
  logic [2:0] state;

  cpu_sequencer #(.WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .cond(cond),
    .flag_z(flag_z), .flag_c(flag_c), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_load(ir_load), .tmp_load(tmp_load), .pc_inc(pc_inc), .pc_load(pc_load),
    .sp_inc(sp_inc), .sp_dec(sp_dec), .reg_we(reg_we), .flags_we(flags_we),
    .halted(halted), .bus_err(bus_err), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, req, we, addr_sel, ir,tmp,pci,pcl,spi,spd,rwe,fwe, halted, bus_err}
  logic [17:0] obs;
  assign obs = {state, mem_req, mem_we, addr_sel, ir_load, tmp_load, pc_inc, pc_load,
                sp_inc, sp_dec, reg_we, flags_we, halted, bus_err};

  localparam logic [2:0] SF = 3'd0, SD = 3'd1, SI = 3'd2, SE = 3'd3, SM = 3'd4, SH = 3'd5;
  localparam logic [1:0] A_PC = 2'd0, A_OP = 2'd1, A_SP = 2'd2;
  localparam logic [7:0] S_IR = 8'h80, S_TMP = 8'h40, S_PCI = 8'h20, S_PCL = 8'h10;
  localparam logic [7:0] S_SPI = 8'h08, S_SPD = 8'h04, S_RWE = 8'h02, S_FWE = 8'h01;

  function automatic logic [17:0] pk(input logic [2:0] st, input logic req, input logic we,
                                     input logic [1:0] as, input logic [7:0] s,
                                     input logic h, input logic be);
    return {st, req, we, as, s, h, be};
  endfunction
  function automatic logic [17:0] rd(input logic [2:0] st, input logic [1:0] as, input logic [7:0] s);
    return pk(st, 1'b1, 1'b0, as, s, 1'b0, 1'b0);
  endfunction
  function automatic logic [17:0] wr(input logic [2:0] st, input logic [1:0] as, input logic [7:0] s);
    return pk(st, 1'b1, 1'b1, as, s, 1'b0, 1'b0);
  endfunction
  function automatic logic [17:0] nq(input logic [2:0] st, input logic [7:0] s);
    return pk(st, 1'b0, 1'b0, A_PC, s, 1'b0, 1'b0);
  endfunction

  typedef struct {
    logic [17:0] exp;
    int          tag;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [7:0]       op;
    logic [2:0]       cd;
    logic             z;
    logic             c;
    int unsigned      n;
    logic [4:0][17:0] exp;
  } vec_t;
  vec_t vecs[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %05h expected %05h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      sb_t e;
      e = sb.pop_front();
      chk($sformatf("cyc%0d", e.tag), obs, e.exp);
    end
  end

  task automatic cyc(input logic ack, input logic [17:0] e, input int tag);
    sb_t s;
    mem_ack = ack;
    s.exp = e;
    s.tag = tag;
    sb.push_back(s);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int tag);
    mem_ack = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk($sformatf("rst_async%0d", tag), obs, '0);
    cyc(1'b0, '0, tag);
    rst_n = 1'b1;
  endtask

  task automatic add(input logic [7:0] op, input logic [2:0] cd, input logic z, input logic c,
                     input int unsigned n, input logic [17:0] e0, input logic [17:0] e1,
                     input logic [17:0] e2, input logic [17:0] e3, input logic [17:0] e4);
    vec_t v;
    v.op = op; v.cd = cd; v.z = z; v.c = c; v.n = n;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [17:0] fet, dec, immw, fw, he, hw;
    logic        a;
    fet  = rd(SF, A_PC, S_IR | S_PCI);
    dec  = nq(SD, 8'h00);
    immw = rd(SI, A_PC, S_TMP | S_PCI);
    fw   = rd(SF, A_PC, 8'h00);
    he   = pk(SH, 1'b0, 1'b0, A_PC, 8'h00, 1'b1, 1'b1);
    hw   = pk(SH, 1'b0, 1'b0, A_PC, 8'h00, 1'b1, 1'b0);

    add(OP_NOP,  3'd0, 1'b0, 1'b0, 2, fet, dec, '0, '0, '0);
    add(OP_ALU,  3'd0, 1'b0, 1'b0, 3, fet, dec, nq(SE, S_RWE | S_FWE), '0, '0);
    add(OP_CMP,  3'd0, 1'b0, 1'b0, 3, fet, dec, nq(SE, S_FWE), '0, '0);
    add(OP_MOV,  3'd0, 1'b0, 1'b0, 3, fet, dec, nq(SE, S_RWE), '0, '0);
    add(8'h77,   3'd0, 1'b0, 1'b0, 3, fet, dec, nq(SE, 8'h00), '0, '0);
    add(OP_LDI,  3'd0, 1'b0, 1'b0, 4, fet, dec, immw, nq(SE, S_RWE), '0);
    add(OP_JMP,  3'b000, 1'b0, 1'b0, 4, fet, dec, immw, nq(SE, S_PCL), '0);
    add(OP_JMP,  3'b001, 1'b0, 1'b0, 4, fet, dec, immw, nq(SE, 8'h00), '0);
    add(OP_JMP,  3'b001, 1'b1, 1'b0, 4, fet, dec, immw, nq(SE, S_PCL), '0);
    add(OP_JMP,  3'b010, 1'b0, 1'b1, 4, fet, dec, immw, nq(SE, S_PCL), '0);
    add(OP_JMP,  3'b010, 1'b1, 1'b0, 4, fet, dec, immw, nq(SE, 8'h00), '0);
    add(OP_JMP,  3'b011, 1'b0, 1'b1, 4, fet, dec, immw, nq(SE, S_PCL), '0);
    add(OP_JMP,  3'b011, 1'b1, 1'b0, 4, fet, dec, immw, nq(SE, 8'h00), '0);
    add(OP_JMP,  3'b100, 1'b0, 1'b1, 4, fet, dec, immw, nq(SE, 8'h00), '0);
    add(OP_JMP,  3'b100, 1'b1, 1'b0, 4, fet, dec, immw, nq(SE, S_PCL), '0);
    add(OP_JMP,  3'b101, 1'b1, 1'b1, 4, fet, dec, immw, nq(SE, 8'h00), '0);
    add(OP_JMP,  3'b111, 1'b0, 1'b0, 4, fet, dec, immw, nq(SE, 8'h00), '0);
    add(OP_LDX,  3'd0, 1'b0, 1'b0, 3, fet, dec, rd(SM, A_OP, S_RWE), '0, '0);
    add(OP_STX,  3'd0, 1'b0, 1'b0, 3, fet, dec, wr(SM, A_OP, 8'h00), '0, '0);
    add(OP_PUSH, 3'd0, 1'b0, 1'b0, 4, fet, dec, nq(SM, S_SPD), wr(SM, A_SP, 8'h00), '0);
    add(OP_POP,  3'd0, 1'b0, 1'b0, 3, fet, dec, rd(SM, A_SP, S_RWE | S_SPI), '0, '0);
    add(OP_CALL, 3'd0, 1'b0, 1'b0, 5, fet, dec, immw, nq(SM, S_SPD), wr(SM, A_SP, S_PCL));
    add(OP_RET,  3'd0, 1'b0, 1'b0, 3, fet, dec, rd(SM, A_SP, S_PCL | S_SPI), '0, '0);

    rst_n = 1'b0; mem_ack = 1'b0; opcode = OP_NOP; cond = 3'd0; flag_z = 1'b0; flag_c = 1'b0;
    @(posedge clk);
    #1;
    do_reset(1);

    // NOP with ack one cycle late
    cyc(1'b0, fw, 10);
    cyc(1'b1, fet, 11);
    cyc(1'b0, dec, 12);

    foreach (vecs[i]) begin
      opcode = vecs[i].op; cond = vecs[i].cd; flag_z = vecs[i].z; flag_c = vecs[i].c;
      for (int unsigned k = 0; k < vecs[i].n; k++)
        cyc(1'b1, vecs[i].exp[k], 1000 + i * 10 + int'(k));
    end

    // Flags only matter in the jump's EXEC cycle
    opcode = OP_JMP; cond = COND_Z; flag_c = 1'b0;
    flag_z = 1'b1;
    cyc(1'b1, fet, 20); cyc(1'b1, dec, 21); cyc(1'b1, immw, 22);
    flag_z = 1'b0;
    cyc(1'b1, nq(SE, 8'h00), 23);
    cyc(1'b1, fet, 24); cyc(1'b1, dec, 25); cyc(1'b1, immw, 26);
    flag_z = 1'b1;
    cyc(1'b1, nq(SE, S_PCL), 27);

    // Ack on the 14th request cycle completes; 15 unanswered cycles halt
    opcode = OP_NOP;
    for (int j = 0; j < 13; j++) cyc(1'b0, fw, 30);
    cyc(1'b1, fet, 31);
    cyc(1'b0, dec, 32);
    for (int j = 0; j < 15; j++) cyc(1'b0, fw, 33);
    for (int j = 0; j < 3; j++) cyc(1'b1, he, 34);
    do_reset(2);

    // Reset asserted while a PUSH write waits
    opcode = OP_PUSH;
    cyc(1'b1, fet, 40); cyc(1'b1, dec, 41); cyc(1'b1, nq(SM, S_SPD), 42);
    for (int j = 0; j < 3; j++) cyc(1'b0, wr(SM, A_SP, 8'h00), 43);
    do_reset(3);
    opcode = OP_NOP;
    cyc(1'b0, fw, 44);
    cyc(1'b1, fet, 45);
    cyc(1'b0, dec, 46);

    // HLT parks the sequencer regardless of mem_ack
    opcode = OP_HLT;
    cyc(1'b1, fet, 50); cyc(1'b1, dec, 51);
    for (int j = 0; j < 100; j++) begin
      a = 1'($urandom_range(0, 1));
      cyc(a, hw, 52);
    end

    chk("sb_drained", 18'(sb.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter WAIT_MAX, default 15: maximum cycles a memory request may wait for mem_ack before a bus error.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  8  decoded opcode from the instruction decoder, OP_* values from symbols.vh.
REQ-005 cond  input  3  jump condition, instruction[5:3].
REQ-006 flag_z, flag_c  input  1 each  ALU zero and carry flags.
REQ-007 mem_ack  input  1  memory completes the current request.
REQ-008 mem_req  output  1  memory request strobe.
REQ-009 mem_we  output  1  1 = write, 0 = read; valid only with mem_req.
REQ-010 addr_sel  output  2  address source: 00 PC, 01 operand register, 10 SP.
REQ-011 ir_load, tmp_load  output  1 each  latch read data into the IR or the immediate/target register.
REQ-012 pc_inc, pc_load, sp_inc, sp_dec, reg_we, flags_we  output  1 each  single-cycle datapath strobes.
REQ-013 halted, bus_err  output  1 each  sticky status flags.
REQ-014 state  output  3  current FSM state, for debug.

Function
REQ-015 States: FETCH=0, DECODE=1, IMM=2, EXEC=3, MEM=4, HALT=5; the encodings 6 and 7 go to FETCH on the next cycle.
REQ-016 FETCH: mem_req=1, mem_we=0, addr_sel=00 until mem_ack; in the ack cycle ir_load=1 and pc_inc=1; next state DECODE.
REQ-017 DECODE (one cycle, no strobes):
- LDI, JMP, CALL -> IMM
- HLT -> HALT
- NOP -> FETCH
- LDX, STX, PUSH, POP, RET -> MEM
- ALU, CMP, MOV, any other opcode -> EXEC
REQ-018 IMM: reads from PC as in FETCH, but on ack asserts tmp_load and pc_inc; next state is EXEC, except CALL goes to MEM.
REQ-019 EXEC, one cycle:
- ALU: reg_we=1, flags_we=1
- CMP: flags_we=1 only
- MOV, LDI: reg_we=1
- JMP: pc_load=1 only if the condition holds
Next state FETCH.
REQ-020 Jump conditions: 000 always; 001 Z; 010 !Z; 011 C; 100 !C; 101-111 never taken.
REQ-021 Flags are sampled in the EXEC cycle of the jump.
REQ-022 MEM accesses:
- LDX: read, addr_sel=01, reg_we on ack
- STX: write, addr_sel=01
- PUSH: sp_dec in the first MEM cycle, then write at addr_sel=10
- POP: read at addr_sel=10, reg_we and sp_inc on ack
- CALL: sp_dec, then write PC at addr_sel=10, then pc_load on ack
- RET: read at addr_sel=10, pc_load and sp_inc on ack
REQ-023 After MEM completes, the next state is FETCH.
REQ-024 Every strobe in REQ-011/REQ-012 is high for at most one cycle per instruction.
REQ-025 mem_req stays high and the address select stays stable from request until ack; mem_ack arriving with mem_req=0 is ignored.
REQ-026 Wait counter: counts the cycles mem_req is high without ack.
- On the ack cycle, the counter clears.
- On reaching WAIT_MAX, go to HALT with bus_err=1 and mem_req=0.
REQ-027 HALT: halted=1, all strobes 0, remains until reset.
REQ-028 CALL pushes the PC value after the target byte (the return address).
REQ-029 SP wrap-around is not checked.

Reset
REQ-030 rst_n low immediately forces state=FETCH, clears the wait counter, and drives all outputs 0 (including halted, bus_err and mem_req), even mid-transaction.
REQ-031 The first request occurs in the first cycle after rst_n deasserts.

Structure
REQ-032 State encodings, addr_sel codes and condition codes belong in the shared symbols.vh beside the OP_* and REG_* definitions.
REQ-033 The wait counter is one sub-module, mem_wait_timer (inputs req and ack; output timeout), instantiated once.
REQ-034 The FSM is a single next-state/output block with registered state.

Verification
REQ-035 NOP with mem_ack one cycle after mem_req -> states FETCH, DECODE, FETCH; one ir_load and one pc_inc.
REQ-036 JMP cond=001 with flag_z=0 -> no pc_load and exactly 2 pc_inc; repeat with flag_z=1 -> pc_load in EXEC.
REQ-037 CALL -> pulses in order: tmp_load, then sp_dec, then a write at addr_sel=10, then pc_load; RET then produces sp_inc and pc_load.
REQ-038 mem_ack held low for 15 cycles during FETCH -> HALT with bus_err=1 and mem_req=0; with ack on cycle 14 -> normal completion.
REQ-039 rst_n pulsed low during a PUSH wait -> all outputs 0 asynchronously; FETCH request in the first cycle after release.
REQ-040 HLT -> halted=1 and no further mem_req for 100 cycles.
